// File: rtl/dif_mode_arbiter.sv
// Two-requester arbiter for the difficulty-mode byte path: round-robin grant,
// optional lock to one source, registered output under a valid/ready handshake.
//
// state | meaning
// IDLE  | no byte presented; eligibility evaluated every cycle
// HOLD  | granted byte on Out with outValid high, waiting for outReady
module dif_mode_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req1,
  input  logic [WIDTH-1:0] Mod1,
  input  logic             req2,
  input  logic [WIDTH-1:0] Mod2,
  input  logic             lockEn,
  input  logic             lockSel,
  input  logic             outReady,
  output logic             outValid,
  output logic [WIDTH-1:0] Out,
  output logic             difMod,
  output logic             gnt1,
  output logic             gnt2,
  output logic             timeoutErr
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_win, last_win_nxt;
  logic             valid_nxt, dif_nxt, gnt1_nxt, gnt2_nxt, to_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             e1, e2, win;

  assign e1  = req1 & (~lockEn | ~lockSel);
  assign e2  = req2 & (~lockEn | lockSel);
  // On a tie the requester that did not win last time gets the path.
  assign win = (e1 & e2) ? ~last_win : e2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_win   <= 1'b1;
      outValid   <= 1'b0;
      Out        <= '0;
      difMod     <= 1'b0;
      gnt1       <= 1'b0;
      gnt2       <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_win   <= last_win_nxt;
      outValid   <= valid_nxt;
      Out        <= out_nxt;
      difMod     <= dif_nxt;
      gnt1       <= gnt1_nxt;
      gnt2       <= gnt2_nxt;
      timeoutErr <= to_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_win_nxt = last_win;
    valid_nxt    = outValid;
    out_nxt      = Out;
    dif_nxt      = difMod;
    gnt1_nxt     = 1'b0;
    gnt2_nxt     = 1'b0;
    to_nxt       = 1'b0;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (e1 | e2) begin
          state_nxt    = HOLD;
          cnt_nxt      = '0;
          last_win_nxt = win;
          valid_nxt    = 1'b1;
          out_nxt      = win ? Mod2 : Mod1;
          dif_nxt      = win;
          gnt1_nxt     = ~win;
          gnt2_nxt     = win;
        end
      end
      HOLD: begin
        // outReady takes priority over the timeout limit in the same cycle.
        if (outReady) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end else if (TO_EN && (cnt == CNT_LAST)) begin
          valid_nxt = 1'b0;
          to_nxt    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dif_mode_arbiter.sv
// Bench for dif_mode_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level reference model each cycle.
module tb_dif_mode_arbiter;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n, req1, req2, lockEn, lockSel, outReady;
  logic [WIDTH-1:0] Mod1, Mod2;
  logic             outValid, difMod, gnt1, gnt2, timeoutErr;
  logic [WIDTH-1:0] Out;

  int vectors = 0;
  int miscompares = 0;

  // reference model: "busy" means a byte is being offered, "waited" counts
  // cycles the consumer has refused it so far
  bit       m_busy, m_last, m_valid, m_dm, m_g1, m_g2, m_to;
  int       m_waited;
  bit [7:0] m_out;

  dif_mode_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req1(req1), .Mod1(Mod1), .req2(req2), .Mod2(Mod2),
    .lockEn(lockEn), .lockSel(lockSel), .outReady(outReady), .outValid(outValid),
    .Out(Out), .difMod(difMod), .gnt1(gnt1), .gnt2(gnt2), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_valid = 0; m_dm = 0; m_out = 0;
    m_g1 = 0; m_g2 = 0; m_to = 0; m_waited = 0;
  endtask

  task automatic model_update();
    bit ok1, ok2, w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_g1 = 0; m_g2 = 0; m_to = 0;
    if (!m_busy) begin
      ok1 = req1 && !(lockEn && lockSel);
      ok2 = req2 && !(lockEn && !lockSel);
      if (ok1 || ok2) begin
        if (ok1 && ok2) w = (m_last == 1) ? 0 : 1;
        else            w = ok2;
        m_out = w ? Mod2 : Mod1;
        m_dm = w; m_last = w; m_g1 = !w; m_g2 = w;
        m_valid = 1; m_busy = 1; m_waited = 0;
      end
    end else if (outReady) begin
      m_valid = 0; m_busy = 0;
    end else begin
      m_waited++;
      if (TIMEOUT != 0 && m_waited == TIMEOUT) begin
        m_valid = 0; m_busy = 0; m_to = 1;
      end
    end
  endtask

  task automatic check_all();
    check("outValid",   outValid,   m_valid);
    check("Out",        Out,        m_out);
    check("difMod",     difMod,     m_dm);
    check("gnt1",       gnt1,       m_g1);
    check("gnt2",       gnt2,       m_g2);
    check("timeoutErr", timeoutErr, m_to);
  endtask

  // called at a negedge: drive, let the edge happen, update model, compare
  task automatic step(input bit r, input bit q1, input bit [7:0] d1, input bit q2,
                      input bit [7:0] d2, input bit le, input bit ls, input bit rdy);
    rst_n = r; req1 = q1; Mod1 = d1; req2 = q2; Mod2 = d2;
    lockEn = le; lockSel = ls; outReady = rdy;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int seen_at, pulses, g2_only;
    rst_n = 0; req1 = 0; req2 = 0; Mod1 = 0; Mod2 = 0;
    lockEn = 0; lockSel = 0; outReady = 0;
    model_reset();
    @(negedge clk);

    step(0, 1, 8'h55, 1, 8'h66, 0, 0, 1);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    check("rst_out", Out, 8'h00);

    // single request
    step(1, 1, 8'hA5, 0, 8'h00, 0, 0, 1);
    check("single_out", Out, 8'hA5);
    check("single_gnt1", gnt1, 1'b1);
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    check("single_drop", outValid, 1'b0);

    // contention round-robin
    for (int i = 0; i < 8; i++) step(1, 1, 8'h11, 1, 8'h22, 0, 0, 1);

    // lock to requester 2, then release
    g2_only = 1;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 8'h5A, 1, 8'h3C, 1, 1, 1);
      if (gnt1) g2_only = 0;
    end
    check("lock_g2_only", g2_only, 1);
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    step(1, 1, 8'h5A, 1, 8'h3C, 0, 0, 1);
    check("unlock_gnt1", gnt1, 1'b1);
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 1);

    // backpressure
    step(1, 0, 8'h00, 1, 8'h7E, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 8'h99, 1, 8'h88, 0, 0, 0);
      check("bp_out", Out, 8'h7E);
    end
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 1);

    // timeout: pulse expected exactly 15 cycles after outValid rose
    step(1, 1, 8'hC3, 0, 8'h00, 0, 0, 0);
    seen_at = -1; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
      if (timeoutErr) begin
        pulses++;
        if (seen_at < 0) seen_at = k;
      end
    end
    check("to_latency", seen_at, 15);
    check("to_pulses", pulses, 1);

    // ready on the limit cycle wins over timeout
    step(1, 1, 8'hD4, 0, 8'h00, 0, 0, 0);
    for (int k = 1; k <= 14; k++) step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 1);
    check("to_ready_wins", timeoutErr, 1'b0);
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);

    // reset mid-HOLD, then tie goes to requester 1
    step(1, 1, 8'hFF, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h12, 1, 8'h34, 0, 0, 0);
    check("rst_mid_out", Out, 8'h00);
    step(1, 1, 8'h12, 1, 8'h34, 0, 0, 1);
    check("post_rst_gnt1", gnt1, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) != 0), $urandom_range(1), 8'($urandom), $urandom_range(1),
           8'($urandom), ($urandom_range(3) == 0), $urandom_range(1),
           ($urandom_range(9) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
